// File: rtl/seg_scan_pkg.sv
// Shared constants, shadow-register layout and segment decode for the
// two-bank six-digit scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 3;

  // Segment patterns, bit order g..a, 1 = lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]         dp;
    logic [NUM_DIGITS-1:0]         blink;
  } bank_shadow_t;

  // All-ones digits decode to blank, so the frame after reset is dark.
  localparam bank_shadow_t SHADOW_RESET = '{digits: '1, dp: '0, blink: '0};

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot_pos(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble-to-7-segment decoder, one instance per display bank.
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(bcd_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver: one-hot strobe over six positions, two segment
// banks in lockstep, frame-aligned input shadowing, per-digit blink and enable.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_a,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_b,
  input  logic [NUM_DIGITS-1:0]         dp_a,
  input  logic [NUM_DIGITS-1:0]         dp_b,
  input  logic [NUM_DIGITS-1:0]         blink_a,
  input  logic [NUM_DIGITS-1:0]         blink_b,
  output logic [NUM_DIGITS-1:0]         SCAN_OUT,
  output logic [7:0]                    SEG_OUT1,
  output logic [7:0]                    SEG_OUT2
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         pre_q,   pre_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  phase_q, phase_d;
  bank_shadow_t          shadow_a_q, shadow_a_d;
  bank_shadow_t          shadow_b_q, shadow_b_d;
  logic [NUM_DIGITS-1:0] scan_q,  scan_d;
  logic [7:0]            seg1_q,  seg1_d;
  logic [7:0]            seg2_q,  seg2_d;

  logic       pre_wrap, frame_end, frame_wrap;
  logic [3:0] nib_a, nib_b;
  logic       dp_bit_a, dp_bit_b, blink_bit_a, blink_bit_b;
  logic [6:0] seg7_a, seg7_b;

  // Timing chain: prescaler -> digit index -> frame counter -> blink phase.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pre_d      = pre_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;

    pre_wrap   = (pre_q == PW'(SCAN_DIV - 1));
    frame_end  = pre_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_wrap = frame_end && (frame_q == FW'(BLINK_FRAMES - 1));

    pre_d = pre_wrap ? '0 : pre_q + PW'(1);

    if (pre_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end) begin
      frame_d    = frame_wrap ? '0 : frame_q + FW'(1);
      shadow_a_d = '{digits: digits_a, dp: dp_a, blink: blink_a};
      shadow_b_d = '{digits: digits_b, dp: dp_b, blink: blink_b};
    end

    if (frame_wrap) phase_d = ~phase_q;
  end

  // Per-position selection from the shadow; all selects read the pre-edge idx.
  always_comb begin
    nib_a       = 4'hF;
    nib_b       = 4'hF;
    dp_bit_a    = 1'b0;
    dp_bit_b    = 1'b0;
    blink_bit_a = 1'b0;
    blink_bit_b = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a       = shadow_a_q.digits[i*DIGIT_W +: DIGIT_W];
        nib_b       = shadow_b_q.digits[i*DIGIT_W +: DIGIT_W];
        dp_bit_a    = shadow_a_q.dp[i];
        dp_bit_b    = shadow_b_q.dp[i];
        blink_bit_a = shadow_a_q.blink[i];
        blink_bit_b = shadow_b_q.blink[i];
      end
    end
  end

  bcd_to_seg u_dec_a (.bcd_i(nib_a), .seg_o(seg7_a));
  bcd_to_seg u_dec_b (.bcd_i(nib_b), .seg_o(seg7_b));

  // Strobe and both buses are computed from the same idx so they switch together.
  always_comb begin
    scan_d = '0;
    seg1_d = '0;
    seg2_d = '0;
    if (enable) begin
      scan_d = onehot_pos(idx_q);
      seg1_d = (phase_q && blink_bit_a) ? 8'h00 : {dp_bit_a, seg7_a};
      seg2_d = (phase_q && blink_bit_b) ? 8'h00 : {dp_bit_b, seg7_b};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      shadow_a_q <= SHADOW_RESET;
      shadow_b_q <= SHADOW_RESET;
      scan_q     <= '0;
      seg1_q     <= '0;
      seg2_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      scan_q     <= scan_d;
      seg1_q     <= seg1_d;
      seg2_q     <= seg2_d;
    end
  end

  assign SCAN_OUT = scan_q;
  assign SEG_OUT1 = seg1_q;
  assign SEG_OUT2 = seg2_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with default parameters
// (4 cycles per position, 24-cycle frame, 96-cycle blink half-period).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] digits_a, digits_b;
  logic [5:0]  dp_a, dp_b, blink_a, blink_b;
  logic [5:0]  scan_out;
  logic [7:0]  seg_out1, seg_out2;

  int tests_run;
  int tests_failed;
  int ecnt;  // posedges since the last reset release; edge 1 is the first

  seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(4)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .enable   (enable),
    .digits_a (digits_a),
    .digits_b (digits_b),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .blink_a  (blink_a),
    .blink_b  (blink_b),
    .SCAN_OUT (scan_out),
    .SEG_OUT1 (seg_out1),
    .SEG_OUT2 (seg_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected strobe for output edge k: position ((k-1)/4) mod 6.
  function automatic logic [5:0] exp_scan(input int k);
    int pos;
    pos = ((k - 1) / 4) % 6;
    return 6'(1 << pos);
  endfunction

  task automatic step();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic run_to(input int k);
    while (ecnt < k) step();
  endtask

  task automatic clear_inputs();
    enable   = 1'b1;
    digits_a = '0;
    digits_b = '0;
    dp_a     = '0;
    dp_b     = '0;
    blink_a  = '0;
    blink_b  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_seg;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({scan_out, seg_out1, seg_out2} !== 22'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: got scan=%b seg1=%h seg2=%h expected all zero", scan_out, seg_out1, seg_out2);
    end
    rst_n = 1'b1;
    ecnt  = 0;
    for (int k = 1; k <= 48; k++) begin
      step();
      exp_seg = (k <= 24) ? 8'h00 : 8'h3F;
      tests_run++;
      if (scan_out !== exp_scan(k)) begin
        tests_failed++;
        $display("FAIL reset_scan edge %0d: got %b expected %b", k, scan_out, exp_scan(k));
      end
      tests_run++;
      if (seg_out1 !== exp_seg || seg_out2 !== exp_seg) begin
        tests_failed++;
        $display("FAIL reset_seg edge %0d: got %h/%h expected %h", k, seg_out1, seg_out2, exp_seg);
      end
    end
  endtask

  task automatic test_digits();
    logic [7:0] exp_a [6];
    exp_a = '{8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};  // '6','5','4','3','2','1'
    clear_inputs();
    digits_a = 24'h123456;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k > 24) begin
        tests_run++;
        if (seg_out1 !== exp_a[((k - 1) / 4) % 6] || seg_out2 !== 8'h3F) begin
          tests_failed++;
          $display("FAIL digits edge %0d: got %h/%h expected %h/3f", k, seg_out1, seg_out2,
                   exp_a[((k - 1) / 4) % 6]);
        end
      end
    end
  endtask

  task automatic test_mid_frame_change();
    clear_inputs();
    digits_a = 24'h123456;
    do_reset();
    run_to(29);
    digits_a = 24'h654321;
    run_to(33);  // frame 1, position 2: still old '4'
    tests_run++;
    if (seg_out1 !== 8'h66) begin
      tests_failed++;
      $display("FAIL midframe_old_pos2: got %h expected 66", seg_out1);
    end
    run_to(45);  // frame 1, position 5: still old '1'
    tests_run++;
    if (seg_out1 !== 8'h06) begin
      tests_failed++;
      $display("FAIL midframe_old_pos5: got %h expected 06", seg_out1);
    end
    run_to(49);  // frame 2, position 0: new '1'
    tests_run++;
    if (seg_out1 !== 8'h06 || scan_out !== 6'b000001) begin
      tests_failed++;
      $display("FAIL midframe_new_pos0: got scan=%b seg=%h expected 000001/06", scan_out, seg_out1);
    end
    run_to(53);  // frame 2, position 1: new '2'
    tests_run++;
    if (seg_out1 !== 8'h5B) begin
      tests_failed++;
      $display("FAIL midframe_new_pos1: got %h expected 5b", seg_out1);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp1;
    clear_inputs();
    digits_a = 24'h000008;
    digits_b = 24'h000008;
    dp_a     = 6'b000001;
    blink_a  = 6'b000001;
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      step();
      // dp_a drops before the frame end that coincides with the first blink wrap.
      if (k == 90) dp_a = 6'b000000;
      if (k > 24 && ((k - 1) / 4) % 6 == 0) begin
        if (k <= 96)                   exp1 = 8'hFF;
        else if (((k - 1) / 96) % 2)   exp1 = 8'h00;
        else                           exp1 = 8'h7F;
        tests_run++;
        if (seg_out1 !== exp1) begin
          tests_failed++;
          $display("FAIL blink_a edge %0d: got %h expected %h", k, seg_out1, exp1);
        end
        tests_run++;
        if (seg_out2 !== 8'h7F || scan_out !== 6'b000001) begin
          tests_failed++;
          $display("FAIL blink_b edge %0d: got scan=%b seg2=%h expected 000001/7f", k, scan_out, seg_out2);
        end
      end
    end
  endtask

  task automatic test_special_codes();
    clear_inputs();
    digits_a = 24'h7000EA;
    digits_b = 24'h0000DC;
    do_reset();
    run_to(25);
    tests_run++;
    if (seg_out1 !== 8'h40 || seg_out2 !== 8'h00 || scan_out !== 6'b000001) begin
      tests_failed++;
      $display("FAIL special_pos0: got scan=%b %h/%h expected 000001 40/00", scan_out, seg_out1, seg_out2);
    end
    run_to(29);
    tests_run++;
    if (seg_out1 !== 8'h00 || seg_out2 !== 8'h00 || scan_out !== 6'b000010) begin
      tests_failed++;
      $display("FAIL special_pos1: got scan=%b %h/%h expected 000010 00/00", scan_out, seg_out1, seg_out2);
    end
    run_to(45);
    tests_run++;
    if (seg_out1 !== 8'h07 || seg_out2 !== 8'h3F) begin
      tests_failed++;
      $display("FAIL special_pos5: got %h/%h expected 07/3f", seg_out1, seg_out2);
    end
  endtask

  task automatic test_enable_and_reset();
    clear_inputs();
    do_reset();
    run_to(49);
    enable = 1'b0;
    for (int k = 50; k <= 60; k++) begin
      step();
      tests_run++;
      if ({scan_out, seg_out1, seg_out2} !== 22'h0) begin
        tests_failed++;
        $display("FAIL disabled edge %0d: got scan=%b %h/%h expected all zero", k, scan_out, seg_out1, seg_out2);
      end
    end
    enable = 1'b1;
    for (int k = 61; k <= 66; k++) begin
      step();
      tests_run++;
      if (scan_out !== exp_scan(k) || seg_out1 !== 8'h3F || seg_out2 !== 8'h3F) begin
        tests_failed++;
        $display("FAIL reenable edge %0d: got scan=%b %h/%h expected %b 3f/3f", k, scan_out, seg_out1,
                 seg_out2, exp_scan(k));
      end
    end
    // Asynchronous reset between edges: outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({scan_out, seg_out1, seg_out2} !== 22'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got scan=%b %h/%h expected all zero", scan_out, seg_out1, seg_out2);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      tests_run++;
      if (scan_out !== exp_scan(k) ||
          seg_out1 !== ((k <= 24) ? 8'h00 : 8'h3F) || seg_out2 !== ((k <= 24) ? 8'h00 : 8'h3F)) begin
        tests_failed++;
        $display("FAIL restart edge %0d: got scan=%b %h/%h expected %b", k, scan_out, seg_out1, seg_out2,
                 exp_scan(k));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ecnt         = 0;
    rst_n        = 1'b0;
    clear_inputs();
    test_reset();
    test_digits();
    test_mid_frame_change();
    test_blink();
    test_special_codes();
    test_enable_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
